// File: rtl/match_window_counter.sv
// Counts rising edges of a detector match line inside programmable back-to-back windows,
// reporting per-window totals and a sticky threshold alarm. Optional MATCH_WINDOW_OVF_EN adds a sticky overflow flag.
module match_window_counter #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned WIN_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             det_in,
  input  logic             clear,
  input  logic [WIN_W-1:0] window_len,
  input  logic [CNT_W-1:0] threshold,
  output logic [CNT_W-1:0] live_count,
  output logic [CNT_W-1:0] last_count,
  output logic             window_done,
  output logic             alarm,
`ifdef MATCH_WINDOW_OVF_EN
  output logic             busy,
  output logic             overflow
`else
  output logic             busy
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_n;
  logic             det_prev;
  logic [WIN_W-1:0] cyc, cyc_n;
  logic [WIN_W-1:0] win_len_q, win_len_n;
  logic [WIN_W-1:0] win_len_eff;
  logic [CNT_W-1:0] live_n, last_n, cnt_inc;
  logic             done_n, alarm_n, busy_n, alarm_chk;
  logic             edge_c, last_cyc;
`ifdef MATCH_WINDOW_OVF_EN
  logic             ovf_n;
`endif

  assign edge_c      = det_in & ~det_prev;
  assign last_cyc    = (cyc == win_len_q - WIN_W'(1));
  assign win_len_eff = (window_len == '0) ? WIN_W'(1) : window_len;

  // State and datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      det_prev    <= 1'b0;
      cyc         <= '0;
      win_len_q   <= WIN_W'(1);
      live_count  <= '0;
      last_count  <= '0;
      window_done <= 1'b0;
      alarm       <= 1'b0;
      busy        <= 1'b0;
`ifdef MATCH_WINDOW_OVF_EN
      overflow    <= 1'b0;
`endif
    end else begin
      state       <= state_n;
      det_prev    <= det_in;
      cyc         <= cyc_n;
      win_len_q   <= win_len_n;
      live_count  <= live_n;
      last_count  <= last_n;
      window_done <= done_n;
      alarm       <= alarm_n;
      busy        <= busy_n;
`ifdef MATCH_WINDOW_OVF_EN
      overflow    <= ovf_n;
`endif
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n   = state;
    cyc_n     = cyc;
    win_len_n = win_len_q;
    live_n    = live_count;
    last_n    = last_count;
    done_n    = 1'b0;
    alarm_n   = alarm;
    alarm_chk = 1'b0;
    cnt_inc   = live_count;
`ifdef MATCH_WINDOW_OVF_EN
    ovf_n     = overflow;
`endif

    case (state)
      IDLE: begin
        if (enable) begin
          state_n   = RUN;
          win_len_n = win_len_eff;
          cyc_n     = '0;
          live_n    = '0;
        end
      end
      RUN: begin
        // Count including this cycle's edge; clear drops the edge
        if (clear) begin
          cnt_inc = '0;
        end else if (edge_c && live_count != CNT_MAX) begin
          cnt_inc = live_count + CNT_W'(1);
        end
`ifdef MATCH_WINDOW_OVF_EN
        if (edge_c && !clear && live_count == CNT_MAX) begin
          ovf_n = 1'b1;
        end
`endif
        if (last_cyc) begin
          last_n    = cnt_inc;
          done_n    = 1'b1;
          live_n    = '0;
          cyc_n     = '0;
          alarm_chk = 1'b1;
          if (enable) begin
            win_len_n = win_len_eff;
          end else begin
            state_n = IDLE;
          end
        end else if (!enable) begin
          state_n = IDLE;
          live_n  = '0;
          cyc_n   = '0;
        end else begin
          live_n    = cnt_inc;
          cyc_n     = cyc + WIN_W'(1);
          alarm_chk = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    if (alarm_chk && threshold != '0 && cnt_inc >= threshold) begin
      alarm_n = 1'b1;
    end

    if (clear) begin
      live_n  = '0;
      last_n  = '0;
      alarm_n = 1'b0;
`ifdef MATCH_WINDOW_OVF_EN
      ovf_n   = 1'b0;
`endif
    end

    busy_n = (state_n == RUN);
  end

endmodule

// File: tb/tb_match_window_counter.sv
// Directed self-checking bench for match_window_counter (CNT_W=4 so saturation is reachable quickly).
module tb_match_window_counter;

  localparam int unsigned CNT_W = 4;
  localparam int unsigned WIN_W = 16;

  logic             clock = 1'b0;
  logic             reset, enable, det_in, clear;
  logic [WIN_W-1:0] window_len;
  logic [CNT_W-1:0] threshold;
  logic [CNT_W-1:0] live_count, last_count;
  logic             window_done, alarm, busy;
`ifdef MATCH_WINDOW_OVF_EN
  logic             overflow;
`endif

  int total = 0;
  int bad   = 0;

  match_window_counter #(.CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .det_in      (det_in),
    .clear       (clear),
    .window_len  (window_len),
    .threshold   (threshold),
    .live_count  (live_count),
    .last_count  (last_count),
    .window_done (window_done),
    .alarm       (alarm),
`ifdef MATCH_WINDOW_OVF_EN
    .busy        (busy),
    .overflow    (overflow)
`else
    .busy        (busy)
`endif
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int e_live, input int e_last,
                         input int e_done, input int e_alarm, input int e_busy);
    chk({tag, ".live"},  32'(live_count),  e_live);
    chk({tag, ".last"},  32'(last_count),  e_last);
    chk({tag, ".done"},  32'(window_done), e_done);
    chk({tag, ".alarm"}, 32'(alarm),       e_alarm);
    chk({tag, ".busy"},  32'(busy),        e_busy);
  endtask

  initial begin
    int exp_live;
    reset = 1'b1; enable = 1'b0; det_in = 1'b0; clear = 1'b0;
    window_len = '0; threshold = '0;

    // Reset with det_in toggling
    det_in = 1'b1; step();
    det_in = 1'b0; step();
    chk_all("reset", 0, 0, 0, 0, 0);
`ifdef MATCH_WINDOW_OVF_EN
    chk("reset.ovf", 32'(overflow), 0);
`endif
    reset = 1'b0; step();

    // Window of 10, pulses at cycles 2,5,9
    window_len = WIN_W'(10); enable = 1'b1; step();
    chk_all("w10.start", 0, 0, 0, 0, 1);
    exp_live = 0;
    for (int k = 1; k <= 10; k++) begin
      det_in = (k == 2 || k == 5 || k == 9);
      step();
      if (det_in) exp_live++;
      if (k == 2 || k == 5 || k == 9) chk($sformatf("w10.k%0d", k), 32'(live_count), exp_live);
    end
    chk_all("w10.end", 0, 3, 1, 0, 1);
    det_in = 1'b0; step();
    chk_all("w10.next", 0, 3, 0, 0, 1);
    // Abort mid-window: no window_done, last_count kept
    enable = 1'b0; step();
    chk_all("abort1", 0, 3, 0, 0, 0);

    // det_in held high 6 cycles inside a 20-cycle window counts once
    window_len = WIN_W'(20); enable = 1'b1; step();
    for (int k = 1; k <= 20; k++) begin
      det_in = (k >= 3 && k <= 8);
      if (k == 20) enable = 1'b0;
      step();
      if (k == 8) chk("w20.held", 32'(live_count), 1);
    end
    chk_all("w20.end", 0, 1, 1, 0, 0);
    step();
    chk_all("w20.idle", 0, 1, 0, 0, 0);

    // Threshold 2, pulses at 1 and 4
    threshold = CNT_W'(2); window_len = WIN_W'(10); enable = 1'b1; step();
    for (int k = 1; k <= 10; k++) begin
      det_in = (k == 1 || k == 4);
      step();
      if (k == 1) chk_all("thr.k1", 1, 1, 0, 0, 1);
      if (k == 4) chk_all("thr.k4", 2, 1, 0, 1, 1);
    end
    chk_all("thr.end", 0, 2, 1, 1, 1);
    det_in = 1'b0; step();
    chk_all("thr.next", 0, 2, 0, 1, 1);
    clear = 1'b1; threshold = '0; step();
    chk_all("thr.clear", 0, 0, 0, 0, 1);
    clear = 1'b0; enable = 1'b0; step();
    chk_all("thr.abort", 0, 0, 0, 0, 0);

    // window_len=0 acts as 1: done every cycle, last alternates 1/0
    window_len = '0; enable = 1'b1; step();
    for (int k = 1; k <= 4; k++) begin
      det_in = (k % 2 == 1);
      step();
      chk_all($sformatf("w0.k%0d", k), 0, (k % 2 == 1) ? 1 : 0, 1, 0, 1);
    end
    det_in = 1'b0; enable = 1'b0; step();
    chk_all("w0.last", 0, 0, 1, 0, 0);
    step();
    chk_all("w0.idle", 0, 0, 0, 0, 0);

    // Saturation at 15 with 17 edges, then abort
    window_len = WIN_W'(100); enable = 1'b1; step();
    for (int i = 1; i <= 17; i++) begin
      det_in = 1'b1; step();
      if (i == 15) begin
        chk("sat.e15", 32'(live_count), 15);
`ifdef MATCH_WINDOW_OVF_EN
        chk("sat.ovf15", 32'(overflow), 0);
`endif
      end
      if (i == 16) begin
        chk("sat.e16", 32'(live_count), 15);
`ifdef MATCH_WINDOW_OVF_EN
        chk("sat.ovf16", 32'(overflow), 1);
`endif
      end
      det_in = 1'b0; step();
    end
    chk_all("sat.e17", 15, 0, 0, 0, 1);
    enable = 1'b0; step();
    chk_all("sat.abort", 0, 0, 0, 0, 0);
`ifdef MATCH_WINDOW_OVF_EN
    chk("sat.ovf_sticky", 32'(overflow), 1);
    clear = 1'b1; step(); clear = 1'b0;
    chk("sat.ovf_clear", 32'(overflow), 0);
`endif

    // Reset in the middle of a window: no window_done afterwards
    window_len = WIN_W'(5); enable = 1'b1; step();
    det_in = 1'b1; step();
    chk_all("rstmid.pre", 1, 0, 0, 0, 1);
    reset = 1'b1; det_in = 1'b0; step();
    chk_all("rstmid.rst", 0, 0, 0, 0, 0);
    reset = 1'b0; enable = 1'b0; step();
    chk_all("rstmid.post", 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
